// File: rtl/usart8251_pkg.sv
// Shared encodings for the 8251-compatible control block: sequencer states,
// status/command bit positions and mode-word fields.
package usart8251_pkg;

  localparam logic [1:0] ST_MODE  = 2'd0;
  localparam logic [1:0] ST_SYNC1 = 2'd1;
  localparam logic [1:0] ST_SYNC2 = 2'd2;
  localparam logic [1:0] ST_CMD   = 2'd3;

  localparam int CMD_TXEN = 0;
  localparam int CMD_RXE  = 2;
  localparam int CMD_ER   = 4;
  localparam int CMD_IR   = 6;

  localparam int SB_TXRDY   = 0;
  localparam int SB_RXRDY   = 1;
  localparam int SB_TXEMPTY = 2;
  localparam int SB_PE      = 3;
  localparam int SB_OE      = 4;
  localparam int SB_FE      = 5;
  localparam int SB_SYNDET  = 6;
  localparam int SB_DSR     = 7;

  localparam logic [7:0] MODE_BAUD_MASK = 8'h03;
  localparam int         MODE_SCS       = 7;

  // Baud-factor field of zero selects synchronous mode.
  function automatic logic is_sync_mode(input logic [7:0] mode);
    return (mode & MODE_BAUD_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/sync_fifo_8251.sv
// Small synchronous FIFO with synchronous flush; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo_8251
  import usart8251_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/usart_ctrl_8251.sv
// 8251-style control block: mode/sync/command write sequencer, status byte,
// sticky receive errors and buffered RX/TX byte paths.
module usart_ctrl_8251
  import usart8251_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 2,
  parameter bit SYNC_EN  = 1'b1
) (
  input  logic       I_CLK,
  input  logic       I_RST_N,
  input  logic       I_CONTROL_EN,
  input  logic       I_DATA_EN,
  input  logic       I_WE,
  input  logic       I_RD,
  input  logic [7:0] I_DATA,
  output logic [7:0] O_DATA,
  output logic [7:0] O_MODE,
  output logic [7:0] O_CMD,
  output logic [7:0] O_SYNC1,
  output logic [7:0] O_SYNC2,
  output logic [1:0] O_STATE,
  output logic [7:0] O_TX_DATA,
  output logic       O_TX_VALID,
  input  logic       I_TX_READY,
  input  logic       I_TXEMPTY,
  input  logic [7:0] I_RX_DATA,
  input  logic       I_RX_VALID,
  input  logic       I_RX_PE,
  input  logic       I_RX_FE,
  input  logic       I_SYNDET,
  input  logic       I_DSR_N,
  output logic       O_RXRDY,
  output logic       O_TXRDY
);

  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic       wr_c, wr_d, rd_d;
  logic       wr_c_q, wr_d_q, rd_d_q;
  logic       wr_c_edge, wr_d_edge, rd_d_fall;
  logic [1:0] state_q, state_d;
  logic [7:0] mode_q, mode_d, cmd_q, cmd_d, sync1_q, sync1_d, sync2_q, sync2_d;
  logic       pe_q, pe_d, oe_q, oe_d, fe_q, fe_d;
  logic [7:0] data_q, data_d, status;
  logic       rxrdy_q, txrdy_q;
  logic       ir, er, err_clr;

  logic             rx_push, rx_accept, rx_full, rx_empty;
  logic [7:0]       rx_head;
  logic [RX_CW-1:0] rx_count;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [TX_CW-1:0] tx_count;

  assign wr_c      = I_CONTROL_EN & I_WE;
  assign wr_d      = I_DATA_EN & I_WE;
  assign rd_d      = I_DATA_EN & I_RD;
  assign wr_c_edge = wr_c & ~wr_c_q;
  assign wr_d_edge = wr_d & ~wr_d_q;
  assign rd_d_fall = rd_d_q & ~rd_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cmd_d   = cmd_q;
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    ir      = 1'b0;
    er      = 1'b0;
    if (wr_c_edge) begin
      case (state_q)
        ST_MODE: begin
          mode_d  = I_DATA;
          state_d = (SYNC_EN && is_sync_mode(I_DATA)) ? ST_SYNC1 : ST_CMD;
        end
        ST_SYNC1: begin
          sync1_d = I_DATA;
          state_d = mode_q[MODE_SCS] ? ST_CMD : ST_SYNC2;
        end
        ST_SYNC2: begin
          sync2_d = I_DATA;
          state_d = ST_CMD;
        end
        default: begin
          if (I_DATA[CMD_IR]) begin
            ir      = 1'b1;
            state_d = ST_MODE;
            cmd_d   = '0;
          end else begin
            cmd_d         = I_DATA;
            cmd_d[CMD_ER] = 1'b0;
            er            = I_DATA[CMD_ER];
          end
        end
      endcase
    end
  end

  // A push into a full RX FIFO survives only if a pop frees a slot this cycle.
  assign rx_push   = I_RX_VALID & cmd_q[CMD_RXE] & (state_q == ST_CMD);
  assign rx_accept = rx_push & (~rx_full | (rd_d_fall & ~rx_empty));
  assign err_clr   = ir | er;
  assign pe_d      = (pe_q & ~err_clr) | (rx_accept & I_RX_PE);
  assign fe_d      = (fe_q & ~err_clr) | (rx_accept & I_RX_FE);
  assign oe_d      = (oe_q & ~err_clr) | (rx_push & ~rx_accept);

  assign tx_push    = wr_d_edge & (state_q == ST_CMD) & ~tx_full;
  assign O_TX_VALID = ~tx_empty & cmd_q[CMD_TXEN];
  assign tx_pop     = O_TX_VALID & I_TX_READY;

  always_comb begin
    status             = '0;
    status[SB_DSR]     = ~I_DSR_N;
    status[SB_SYNDET]  = I_SYNDET;
    status[SB_FE]      = fe_q;
    status[SB_OE]      = oe_q;
    status[SB_PE]      = pe_q;
    status[SB_TXEMPTY] = (tx_count == '0) & I_TXEMPTY;
    status[SB_RXRDY]   = (rx_count != '0);
    status[SB_TXRDY]   = ~tx_full;
  end

  always_comb begin
    data_d = data_q;
    if (I_CONTROL_EN & I_RD) data_d = status;
    else if (rd_d)           data_d = rx_head;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      wr_c_q  <= 1'b0;
      wr_d_q  <= 1'b0;
      rd_d_q  <= 1'b0;
      state_q <= ST_MODE;
      mode_q  <= '0;
      cmd_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      pe_q    <= 1'b0;
      oe_q    <= 1'b0;
      fe_q    <= 1'b0;
      data_q  <= '0;
      rxrdy_q <= 1'b0;
      txrdy_q <= 1'b0;
    end else begin
      wr_c_q  <= wr_c;
      wr_d_q  <= wr_d;
      rd_d_q  <= rd_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      cmd_q   <= cmd_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pe_q    <= pe_d;
      oe_q    <= oe_d;
      fe_q    <= fe_d;
      data_q  <= data_d;
      rxrdy_q <= status[SB_RXRDY] & cmd_q[CMD_RXE];
      txrdy_q <= status[SB_TXRDY] & cmd_q[CMD_TXEN];
    end
  end

  sync_fifo_8251 #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i  (I_CLK),
    .rst_n_i(I_RST_N),
    .flush_i(ir),
    .push_i (rx_push),
    .pop_i  (rd_d_fall),
    .din_i  (I_RX_DATA),
    .dout_o (rx_head),
    .full_o (rx_full),
    .empty_o(rx_empty),
    .count_o(rx_count)
  );

  sync_fifo_8251 #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i  (I_CLK),
    .rst_n_i(I_RST_N),
    .flush_i(ir),
    .push_i (tx_push),
    .pop_i  (tx_pop),
    .din_i  (I_DATA),
    .dout_o (O_TX_DATA),
    .full_o (tx_full),
    .empty_o(tx_empty),
    .count_o(tx_count)
  );

  assign O_DATA  = data_q;
  assign O_MODE  = mode_q;
  assign O_CMD   = cmd_q;
  assign O_SYNC1 = sync1_q;
  assign O_SYNC2 = sync2_q;
  assign O_STATE = state_q;
  assign O_RXRDY = rxrdy_q;
  assign O_TXRDY = txrdy_q;

endmodule

// File: doc/usart_ctrl_8251.md
Name: usart_ctrl_8251

Overview:
- Parametrised successor to the PC-8001 8251 control-register block: full mode/sync/command write sequencer, status register, and buffered RX/TX data paths.
- Adds synchronous-mode sync-character loading, sticky error flags with Error Reset, and parametrised RX/TX FIFOs.
- Sits between the Z80 I/O decode (ports 0x20 data / 0x21 control) and the bit-level serial TX/RX engines (CMT/RS-232C).

Parameters:
- RX_DEPTH, 4: receive FIFO entries, power of two, ≥2.
- TX_DEPTH, 2: transmit FIFO entries, power of two, ≥2.
- SYNC_EN, 1: 1 = synchronous-mode sync-char states exist; 0 = sync mode words go straight to CMD.

Ports:
- I_CLK  in  1  system clock.
- I_RST_N  in  1  asynchronous active-low reset.
- I_CONTROL_EN  in  1  control port (C/D=1) selected.
- I_DATA_EN  in  1  data port (C/D=0) selected.
- I_WE  in  1  CPU write strobe (level, may span many cycles).
- I_RD  in  1  CPU read strobe (level).
- I_DATA  in  8  CPU write data.
- O_DATA  out  8  CPU read data (status or RX head).
- O_MODE  out  8  latched mode word.
- O_CMD  out  8  latched command word (bit6 always 0).
- O_SYNC1, O_SYNC2  out  8 each  sync characters.
- O_STATE  out  2  0=MODE 1=SYNC1 2=SYNC2 3=CMD.
- O_TX_DATA  out  8  TX FIFO head to serializer.
- O_TX_VALID  out  1  TX head valid.
- I_TX_READY  in  1  serializer accepts head.
- I_TXEMPTY  in  1  serializer shift register idle.
- I_RX_DATA  in  8  received byte.
- I_RX_VALID  in  1  one-cycle received-byte pulse.
- I_RX_PE, I_RX_FE  in  1 each  parity/framing error qualifying I_RX_VALID.
- I_SYNDET  in  1  sync-detect level from RX engine.
- I_DSR_N  in  1  DSR pin.
- O_RXRDY, O_TXRDY  out  1 each  interrupt/pin-level ready flags.

Behaviour:
- Reset (I_RST_N=0, async): state MODE, O_MODE/O_CMD/O_SYNC1/O_SYNC2=0x00, FIFOs empty, PE/OE/FE=0, O_DATA=0x00, O_TX_VALID/O_RXRDY/O_TXRDY=0.
- Access qualification: wr_c=I_CONTROL_EN&I_WE, wr_d=I_DATA_EN&I_WE, rd_d=I_DATA_EN&I_RD. Exactly one action per strobe, taken in the cycle after a 0→1 edge of the strobe (registered previous value); holding a strobe has no further effect.
- Sequencer on wr_c edge:
  - MODE: latch O_MODE. If I_DATA[1:0]=00 and SYNC_EN, go SYNC1; else go CMD.
  - SYNC1: latch O_SYNC1. If O_MODE[7]=1 (single sync), go CMD; else go SYNC2.
  - SYNC2: latch O_SYNC2, go CMD.
  - CMD with I_DATA[6]=1 (IR): internal reset. Go MODE, O_CMD=0x00, flush both FIFOs, clear PE/OE/FE. O_MODE and sync regs are retained.
  - CMD otherwise: O_CMD=I_DATA. If I_DATA[4]=1 (ER), clear PE/OE/FE; ER is not stored (O_CMD[4]=0).
- Status byte, bit7..0: ~I_DSR_N, I_SYNDET, FE, OE, PE, TxEMPTY, RxRDY, TxRDY.
  - TxRDY = TX FIFO not full.
  - RxRDY = RX FIFO non-empty.
  - TxEMPTY = TX FIFO empty & I_TXEMPTY.
- O_DATA: registered every cycle. Status when I_CONTROL_EN&I_RD; RX head (0x00 if empty) when I_DATA_EN&I_RD; otherwise hold.
- RX FIFO push: on I_RX_VALID when O_CMD[2] (RxE)=1 and state=CMD.
  - If full: byte dropped, OE set.
  - On accepted push, PE|=I_RX_PE and FE|=I_RX_FE.
- RX FIFO pop: on rd_d 1→0 edge (read completes) if non-empty. Push and pop in the same cycle: both occur, count unchanged. A push into a full FIFO coincident with a pop is accepted without OE.
- Error set and ER in the same cycle: set wins.
- TX FIFO push: on wr_d edge in state CMD if not full. Otherwise the write is ignored, with no flag.
- TX FIFO pop: when O_TX_VALID&I_TX_READY. O_TX_VALID = non-empty & O_CMD[0] (TxEN).
- O_RXRDY = RxRDY & O_CMD[2]. O_TXRDY = TxRDY & O_CMD[0]. Both registered, one cycle after the cause.
- Counters are $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Decomposition:
- Shared package usart8251_pkg: state encoding, status bit indices, command bit indices (TXEN=0, RXE=2, ER=4, IR=6), mode field masks.
- One sub-module sync_fifo_8251 (WIDTH, DEPTH), instantiated once for RX and once for TX: push/pop/full/empty/count, plus a synchronous flush.

Test Plan:
- Reset, then hold wr_c for 10 cycles with 0x4E → only one write: O_STATE=3, O_MODE=0x4E. Then wr_c 0x40 → O_STATE=0, O_CMD=0x00, O_MODE still 0x4E.
- Sync double: mode 0x0C, 0x16, 0x17 → states 1,2,3, O_SYNC1=0x16, O_SYNC2=0x17. Mode 0x8C then 0x16 → CMD directly. SYNC_EN=0 with 0x0C → CMD after one write.
- Command 0x05, push 5 RX bytes 0xA1..0xA5 (RX_DEPTH=4) → status 0x13-type value with OE=1, RxRDY=1. Four data reads return 0xA1..0xA4, then RxRDY=0. Command 0x15 → OE cleared, O_CMD=0x05.
- Command 0x01, I_TX_READY=0, write 0x31,0x32,0x33 → TxRDY=0 after the 2nd write, 3rd write dropped. Raise I_TX_READY → 0x31 then 0x32 on O_TX_DATA, then TxEMPTY=1 when I_TXEMPTY=1.
- I_RX_VALID with I_RX_FE=1 coincident with an ER command write → FE reads 1.
- Assert I_RST_N=0 mid-transfer with 2 bytes in each FIFO → all outputs at reset values immediately, without waiting for a clock edge.
